// File: rtl/jtgng_romrq_arb.sv
// Three-client ROM read arbiter in front of the SDRAM controller.
// It keeps one cached 32-bit line per client and issues two-word burst reads on a miss.
module jtgng_romrq_arb #(
    parameter logic [21:0] OFFSET0 = 22'd0,
    parameter logic [21:0] OFFSET1 = 22'd0,
    parameter logic [21:0] OFFSET2 = 22'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,

    input  logic        slot0_cs,
    input  logic [21:0] slot0_addr,
    output logic        slot0_ok,
    output logic [15:0] slot0_dout,

    input  logic        slot1_cs,
    input  logic [21:0] slot1_addr,
    output logic        slot1_ok,
    output logic [15:0] slot1_dout,

    input  logic        slot2_cs,
    input  logic [21:0] slot2_addr,
    output logic        slot2_ok,
    output logic [15:0] slot2_dout,

    output logic        read_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic [31:0] data_read,
    input  logic        data_rdy,
    output logic        refresh_en
);

    localparam int unsigned AW    = 22;
    localparam int unsigned TW    = AW - 1;
    localparam int unsigned DW    = 16;
    localparam int unsigned LW    = 2 * DW;
    localparam int unsigned NSLOT = 3;
    localparam int unsigned SW    = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic              read_req_q, read_req_d;
    logic [AW-1:0]     sdram_addr_q, sdram_addr_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [TW-1:0]     ltag_q, ltag_d;
    logic              refresh_q, refresh_d;
    logic [NSLOT-1:0]  valid_q;
    logic [LW-1:0]     line_q [NSLOT];
    logic [TW-1:0]     tag_q  [NSLOT];
    logic              fill;

    logic [NSLOT-1:0]  cs;
    logic [AW-1:0]     addr [NSLOT];
    logic [NSLOT-1:0]  hit;
    logic [NSLOT-1:0]  miss;
    logic [DW-1:0]     dout [NSLOT];
    logic [SW-1:0]     pick;
    logic [AW-1:0]     pick_addr;
    logic [AW-1:0]     pick_off;

    assign cs      = {slot2_cs, slot1_cs, slot0_cs};
    assign addr[0] = slot0_addr;
    assign addr[1] = slot1_addr;
    assign addr[2] = slot2_addr;

    // Zero-latency cache lookup per client
    always_comb begin
        hit = '0;
        for (int n = 0; n < NSLOT; n++) begin
            hit[n]  = cs[n] & valid_q[n] & (tag_q[n] == addr[n][AW-1:1]);
            dout[n] = addr[n][0] ? line_q[n][LW-1:DW] : line_q[n][DW-1:0];
        end
        miss = cs & ~hit;
    end

    assign slot0_ok   = hit[0];
    assign slot1_ok   = hit[1];
    assign slot2_ok   = hit[2];
    assign slot0_dout = dout[0];
    assign slot1_dout = dout[1];
    assign slot2_dout = dout[2];

    // Fixed priority: slot 0 over slot 1 over slot 2
    always_comb begin
        pick      = SW'(2);
        pick_addr = slot2_addr;
        pick_off  = OFFSET2;
        if (miss[0]) begin
            pick      = SW'(0);
            pick_addr = slot0_addr;
            pick_off  = OFFSET0;
        end else if (miss[1]) begin
            pick      = SW'(1);
            pick_addr = slot1_addr;
            pick_off  = OFFSET1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an accepted ack wins over a late download abort
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (!downloading && (|miss)) state_d = WAIT_ACK;
            WAIT_ACK:  begin
                if (sdram_ack)        state_d = WAIT_DATA;
                else if (downloading) state_d = IDLE;
            end
            WAIT_DATA: if (data_rdy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Request, latch and fill controls
    always_comb begin
        read_req_d   = read_req_q;
        sdram_addr_d = sdram_addr_q;
        sel_d        = sel_q;
        ltag_d       = ltag_q;
        fill         = 1'b0;
        refresh_d    = (state_q == IDLE) & ~(|miss) & ~downloading;
        unique case (state_q)
            IDLE: begin
                if (!downloading && (|miss)) begin
                    read_req_d   = 1'b1;
                    sdram_addr_d = pick_off + {pick_addr[AW-1:1], 1'b0};
                    sel_d        = pick;
                    ltag_d       = pick_addr[AW-1:1];
                end
            end
            WAIT_ACK:  if (sdram_ack || downloading) read_req_d = 1'b0;
            WAIT_DATA: fill = data_rdy;
            default:   read_req_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_req_q   <= 1'b0;
            sdram_addr_q <= '0;
            sel_q        <= '0;
            ltag_q       <= '0;
            refresh_q    <= 1'b0;
            valid_q      <= '0;
        end else begin
            read_req_q   <= read_req_d;
            sdram_addr_q <= sdram_addr_d;
            sel_q        <= sel_d;
            ltag_q       <= ltag_d;
            refresh_q    <= refresh_d;
            // A download invalidates every line, even one filled this cycle
            for (int n = 0; n < NSLOT; n++) begin
                if (downloading)                   valid_q[n] <= 1'b0;
                else if (fill && sel_q == SW'(n))  valid_q[n] <= 1'b1;
            end
        end
    end

    // Line and tag storage carries no reset; valid bits guard it
    always_ff @(posedge clk) begin
        for (int n = 0; n < NSLOT; n++) begin
            if (fill && sel_q == SW'(n)) begin
                line_q[n] <= data_read;
                tag_q[n]  <= ltag_q;
            end
        end
    end

    assign read_req   = read_req_q;
    assign sdram_addr = sdram_addr_q;
    assign refresh_en = refresh_q;

endmodule

// File: tb/tb_jtgng_romrq_arb.sv
// Directed bench for jtgng_romrq_arb: a tiny controller model plus a request scoreboard.
// Expected SDRAM addresses are queued by the stimulus and popped by a monitor on each new read_req.
module tb_jtgng_romrq_arb;

    localparam logic [21:0] OFF0 = 22'h000040;
    localparam logic [21:0] OFF1 = 22'h100000;
    localparam logic [21:0] OFF2 = 22'h3FFFFE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        downloading;
    logic        slot0_cs, slot1_cs, slot2_cs;
    logic [21:0] slot0_addr, slot1_addr, slot2_addr;
    logic        slot0_ok, slot1_ok, slot2_ok;
    logic [15:0] slot0_dout, slot1_dout, slot2_dout;
    logic        read_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic [31:0] data_read;
    logic        data_rdy;
    logic        refresh_en;

    int errors = 0;
    int checks = 0;
    logic [21:0] exp_q [$];
    logic        rr_prev = 1'b0;

    jtgng_romrq_arb #(
        .OFFSET0(OFF0),
        .OFFSET1(OFF1),
        .OFFSET2(OFF2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .downloading(downloading),
        .slot0_cs   (slot0_cs),
        .slot0_addr (slot0_addr),
        .slot0_ok   (slot0_ok),
        .slot0_dout (slot0_dout),
        .slot1_cs   (slot1_cs),
        .slot1_addr (slot1_addr),
        .slot1_ok   (slot1_ok),
        .slot1_dout (slot1_dout),
        .slot2_cs   (slot2_cs),
        .slot2_addr (slot2_addr),
        .slot2_ok   (slot2_ok),
        .slot2_dout (slot2_dout),
        .read_req   (read_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .data_read  (data_read),
        .data_rdy   (data_rdy),
        .refresh_en (refresh_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Controller model: ack 2 cycles after read_req rises, data_rdy 4 cycles after ack
    task automatic serve(input logic [31:0] data);
        int waited = 0;
        while (!read_req && waited < 20) begin
            tick(1);
            waited++;
        end
        if (!read_req) begin
            check("serve_timeout", 32'(read_req), 32'd1);
        end else begin
            tick(1);
            sdram_ack = 1'b1;
            tick(1);
            sdram_ack = 1'b0;
            tick(3);
            data_rdy  = 1'b1;
            data_read = data;
            tick(1);
            data_rdy  = 1'b0;
        end
    endtask

    // Scoreboard monitor: every new request must match the oldest expected address
    initial begin
        forever begin
            @(negedge clk);
            if (read_req && !rr_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_req: got read_req addr %h, none expected", sdram_addr);
                end else begin
                    logic [21:0] e;
                    e = exp_q.pop_front();
                    if (sdram_addr !== e) begin
                        errors++;
                        $display("FAIL req_addr: got %h expected %h", sdram_addr, e);
                    end
                end
            end
            if (read_req) begin
                checks++;
                if (refresh_en !== 1'b0) begin
                    errors++;
                    $display("FAIL refresh_during_req: got refresh_en %b expected 0", refresh_en);
                end
            end
            rr_prev = read_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; downloading = 1'b0;
        slot0_cs = 1'b0; slot1_cs = 1'b0; slot2_cs = 1'b0;
        slot0_addr = '0; slot1_addr = '0; slot2_addr = '0;
        sdram_ack = 1'b0; data_read = '0; data_rdy = 1'b0;

        // Reset state
        tick(3);
        check("rst_read_req", 32'(read_req), 32'd0);
        check("rst_sdram_addr", 32'(sdram_addr), 32'd0);
        check("rst_refresh", 32'(refresh_en), 32'd0);
        check("rst_ok", {29'd0, slot2_ok, slot1_ok, slot0_ok}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("idle_refresh", 32'(refresh_en), 32'd1);

        // Single miss on slot 1, then hit on the other half of the line
        exp_q.push_back(22'h100102);
        slot1_cs = 1'b1; slot1_addr = 22'h000103;
        #1 check("miss_ok_low", 32'(slot1_ok), 32'd0);
        tick(1);
        check("miss_read_req", 32'(read_req), 32'd1);
        serve(32'hBEEF_1234);
        check("s1_ok", 32'(slot1_ok), 32'd1);
        check("s1_dout_odd", 32'(slot1_dout), 32'h0000BEEF);
        slot1_addr = 22'h000102;
        #1 check("s1_dout_even", 32'(slot1_dout), 32'h00001234);
        check("s1_ok_even", 32'(slot1_ok), 32'd1);
        tick(3);
        check("s1_no_rereq", 32'(read_req), 32'd0);
        slot1_cs = 1'b0;

        // Priority: slot 0 and slot 2 miss together; slot 2 also exercises offset wrap
        exp_q.push_back(22'h000050);
        exp_q.push_back(22'h000002);
        slot0_cs = 1'b1; slot0_addr = 22'h000010;
        slot2_cs = 1'b1; slot2_addr = 22'h000004;
        tick(1);
        serve(32'hAAAA_5555);
        check("p_s0_ok", 32'(slot0_ok), 32'd1);
        check("p_s0_dout", 32'(slot0_dout), 32'h00005555);
        check("p_s2_ok_low", 32'(slot2_ok), 32'd0);
        check("p_req_gap", 32'(read_req), 32'd0);
        tick(1);
        check("p_s2_req", 32'(read_req), 32'd1);
        serve(32'h2222_1111);
        check("p_s2_ok", 32'(slot2_ok), 32'd1);
        check("p_s2_dout", 32'(slot2_dout), 32'h00001111);
        check("p_s0_still_ok", 32'(slot0_ok), 32'd1);
        slot2_cs = 1'b0;

        // Download invalidates, then address change while data is in flight
        downloading = 1'b1;
        tick(1);
        check("dl_s0_ok", 32'(slot0_ok), 32'd0);
        check("dl_refresh", 32'(refresh_en), 32'd0);
        tick(2);
        check("dl_no_req", 32'(read_req), 32'd0);
        downloading = 1'b0;
        exp_q.push_back(22'h000050);
        tick(1);
        check("mf_req", 32'(read_req), 32'd1);
        tick(1);
        sdram_ack = 1'b1;
        tick(1);
        sdram_ack = 1'b0;
        slot0_addr = 22'h000020;
        exp_q.push_back(22'h000060);
        tick(2);
        data_rdy = 1'b1; data_read = 32'h3333_4444;
        tick(1);
        data_rdy = 1'b0;
        check("mf_stale_ok", 32'(slot0_ok), 32'd0);
        serve(32'h5555_6666);
        check("mf_ok", 32'(slot0_ok), 32'd1);
        check("mf_dout", 32'(slot0_dout), 32'h00006666);
        slot0_cs = 1'b0;

        // Download abort while waiting for ack
        exp_q.push_back(22'h100200);
        slot1_cs = 1'b1; slot1_addr = 22'h000200;
        tick(1);
        check("ab_req", 32'(read_req), 32'd1);
        downloading = 1'b1;
        tick(1);
        check("ab_req_drop", 32'(read_req), 32'd0);
        check("ab_ok", {29'd0, slot2_ok, slot1_ok, slot0_ok}, 32'd0);
        tick(3);
        check("ab_no_req", 32'(read_req), 32'd0);
        downloading = 1'b0;
        exp_q.push_back(22'h100200);
        serve(32'h7777_8888);
        check("ab_ok_after", 32'(slot1_ok), 32'd1);
        check("ab_dout", 32'(slot1_dout), 32'h00008888);
        slot1_cs = 1'b0;

        // Asynchronous reset during WAIT_DATA, then a stray data_rdy
        exp_q.push_back(22'h000004);
        slot2_cs = 1'b1; slot2_addr = 22'h000006;
        tick(1);
        tick(1);
        sdram_ack = 1'b1;
        tick(1);
        sdram_ack = 1'b0;
        #2 rst_n = 1'b0;
        slot2_cs = 1'b0;
        #1;
        check("ar_read_req", 32'(read_req), 32'd0);
        check("ar_refresh", 32'(refresh_en), 32'd0);
        check("ar_sdram_addr", 32'(sdram_addr), 32'd0);
        check("ar_ok", {29'd0, slot2_ok, slot1_ok, slot0_ok}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        data_rdy = 1'b1; data_read = 32'h9999_AAAA;
        tick(1);
        data_rdy = 1'b0;
        exp_q.push_back(22'h000004);
        slot2_cs = 1'b1; slot2_addr = 22'h000006;
        #1 check("ar_stray_ok", 32'(slot2_ok), 32'd0);
        serve(32'hBBBB_CCCC);
        check("ar_refill_ok", 32'(slot2_ok), 32'd1);
        check("ar_refill_dout", 32'(slot2_dout), 32'h0000CCCC);
        slot2_cs = 1'b0;
        tick(2);
        check("end_refresh", 32'(refresh_en), 32'd1);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtgng_romrq_arb.md
# jtgng_romrq_arb

Three-client ROM read arbiter that sits directly upstream of the SDRAM controller. It turns per-client 16-bit ROM fetches into 32-bit (two-word burst) SDRAM read requests. It caches the last 32-bit line per client and drives the controller's read_req/sdram_addr handshake. It also tells the controller when an auto-refresh may be slotted in.

## Interface
Parameters:
- OFFSET0, 22'd0, SDRAM word offset added to slot 0 addresses
- OFFSET1, 22'd0, SDRAM word offset added to slot 1 addresses
- OFFSET2, 22'd0, SDRAM word offset added to slot 2 addresses

Ports:
- clk  in  1  system clock; the SDRAM controller runs on the same clock
- rst_n  in  1  asynchronous, active-low reset
- downloading  in  1  ROM download in progress
- slotN_cs  in  1  client N (N=0,1,2) wants data
- slotN_addr  in  22  client N 16-bit word address, relative to OFFSETN
- slotN_ok  out  1  slotN_dout is valid for the current slotN_addr
- slotN_dout  out  16  requested word
- read_req  out  1  read request to the controller
- sdram_addr  out  22  SDRAM word address, always even
- sdram_ack  in  1  controller accepted the request (1-cycle pulse)
- data_read  in  32  controller data; [15:0] = even word, [31:16] = odd word
- data_rdy  in  1  data_read valid (1-cycle pulse)
- refresh_en  out  1  controller may issue auto-refresh

## Operation
- Per-slot cache: line[31:0], tag[20:0], valid.
- hitN = slotN_cs & validN & (tagN == slotN_addr[21:1]).
- slotN_ok = hitN, combinational.
- slotN_dout = slotN_addr[0] ? lineN[31:16] : lineN[15:0], combinational.
- missN = slotN_cs & ~hitN.
- FSM states IDLE, WAIT_ACK, WAIT_DATA.
- IDLE:
  - If !downloading and any missN, select the lowest N (priority 0>1>2).
  - Latch sel=N and ltag=slotN_addr[21:1].
  - Register read_req<=1 and sdram_addr<=OFFSETN+{slotN_addr[21:1],1'b0}. The sum is modulo 2^22 and wraps silently.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - Hold read_req and sdram_addr.
  - On sdram_ack: read_req<=0, go to WAIT_DATA.
  - If downloading rises before ack: read_req<=0, go to IDLE, fill nothing.
- WAIT_DATA:
  - On data_rdy: line[sel]<=data_read, tag[sel]<=ltag, valid[sel]<=1, go to IDLE.
  - The fill uses the latched tag even if the client address changed meanwhile. The client then stays missed and is re-requested.
  - downloading does not abort this state; the controller completes the burst.
- Misses from other slots wait until IDLE. There is no preemption of an in-flight request.
- While downloading=1, all valid bits clear every cycle, and no new request starts.
- refresh_en = (state==IDLE) & ~(miss0|miss1|miss2) & ~downloading, registered.
- A data_rdy outside WAIT_DATA and an sdram_ack outside WAIT_ACK are ignored.
- Reset (rst_n low, any time including mid-transaction):
  - read_req=0, sdram_addr=0, refresh_en=0.
  - All valid=0, state=IDLE, sel=0.
  - Line and tag contents are don't-care.
  - Outputs: slotN_ok=0; slotN_dout is unspecified.

## Timing
- Hit: ok and dout are valid in the same cycle as cs/addr, with zero-cycle latency.
- Miss issue: read_req goes high on the first edge after miss is seen in IDLE.
- read_req drops on the edge that samples sdram_ack high. The controller samples read_req only in its idle state, so it does not see a second request.
- Against a controller with ack 2 cycles after read_req rises and data_rdy 4 cycles after ack:
  - The fill is visible, and ok rises, on the edge that samples data_rdy.
  - Total latency is 7 cycles from miss to ok when no refresh intervenes.
- Back-to-back misses: the next read_req rises on the edge after the fill, which is the cycle after returning to IDLE.
- Minimum spacing between the ends of two requests is therefore WAIT_ACK + WAIT_DATA + 1.
- refresh_en lags its condition by one cycle. It is low in every cycle in which read_req is high.

## Test plan
- Reset then single miss:
  - Stimulus: slot1_cs=1, slot1_addr=22'h000103, OFFSET1=22'h100000.
  - sdram_addr=22'h100102 and read_req=1 one cycle later.
  - After ack and data_rdy with data_read=32'hBEEF_1234: slot1_ok=1 and slot1_dout=16'hBEEF.
  - Changing slot1_addr to 22'h000102 gives slot1_dout=16'h1234 with no new read_req.
- Priority:
  - Stimulus: slot0 and slot2 miss in the same cycle.
  - slot0 is served first; slot2's read_req rises the cycle after slot0's fill.
  - slot2_ok is never asserted with slot0's line.
- Address change mid-flight:
  - Stimulus: slot0_addr changes from 22'h10 to 22'h20 during WAIT_DATA.
  - The fill writes tag 22'h10>>1 and slot0_ok stays 0.
  - A new request to sdram_addr=OFFSET0+22'h20 follows.
- Download abort:
  - Stimulus: downloading rises in WAIT_ACK.
  - read_req drops next cycle and all ok=0.
  - No request starts while downloading=1.
  - After it falls, the miss is re-requested.
- Offset wrap:
  - Stimulus: OFFSET2=22'h3FFFFE, slot2_addr=22'h000004.
  - sdram_addr=22'h000002.
- Async reset:
  - Stimulus: rst_n pulsed low during WAIT_DATA.
  - Immediately read_req=0, refresh_en=0 and all ok=0.
  - A stray data_rdy afterwards fills nothing.
